usb_utm_rx: RTL and testbench

//  UTM receive side, paired with the UTM transmit block under the UTMI macrocell.
//  - Synchronises the differential line inputs and reports line_state.
//  - Recovers bit timing by oversampling, then NRZI-decodes and bit-unstuffs.
//  - Detects SYNC and EOP, and delivers bytes on the UTMI rx interface.

---
 rtl/usb_utm_rx.sv | 240 ++++++++++++++++++++++++
 tb/tb_usb_utm_rx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_utm_rx.sv
// USB full-speed UTM receiver: synchronises D+/D-, recovers bit timing by oversampling,
// NRZI-decodes and unstuffs the bit stream, frames SYNC/EOP and delivers bytes on UTMI rx.
module usb_utm_rx #(
  parameter int CLK_PER_BIT = 4,
  parameter int SYNC_ZEROS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_rx,
  input  logic       dn_rx,
  input  logic       tx_oen,
  input  logic       suspend_m,
  output logic [1:0] line_state,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  localparam int PH_W = $clog2(CLK_PER_BIT);
  localparam int ZW   = $clog2(SYNC_ZEROS + 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLK_PER_BIT / 2);
  localparam logic [ZW-1:0]   ZEROS_MIN = ZW'(SYNC_ZEROS);
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  typedef enum logic [2:0] {
    RX_IDLE_S,
    RX_SYNC_S,
    RX_DATA_S,
    RX_EOP_S,
    RX_ERR_S
  } rx_state_e;

  logic [1:0]      sync1_q, sync2_q, ls_q, ls_prev_q;
  logic [PH_W-1:0] phase_q, phase_cur;
  logic            trans, smp, se0, lvl, dbit, stuff_err, stuffed, blocked;

  rx_state_e       state_q, state_d;
  logic [2:0]      ones_q, ones_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [ZW-1:0]   zeros_q, zeros_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            prev_q, prev_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            active_q, active_d;

  // Stage p0..p2: two-flop synchroniser plus line-state register; line bits are {dn, dp}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= LS_J;
      sync2_q   <= LS_J;
      ls_q      <= LS_J;
      ls_prev_q <= LS_J;
      phase_q   <= '0;
    end else begin
      sync1_q   <= {dn_rx, dp_rx};
      sync2_q   <= sync1_q;
      ls_q      <= sync2_q;
      ls_prev_q <= ls_q;
      phase_q   <= phase_cur + 1'b1;
    end
  end

  // Any line change realigns the bit cell so the sample lands mid-bit.
  assign trans     = (ls_q != ls_prev_q);
  assign phase_cur = trans ? '0 : phase_q;
  assign smp       = (phase_cur == PH_SAMPLE);
  assign se0       = (ls_q == LS_SE0);
  assign lvl       = ls_q[0];
  assign dbit      = (lvl == prev_q);
  assign stuff_err = (ones_q == 3'd6) && dbit;
  assign stuffed   = (ones_q == 3'd6) && !dbit;
  assign blocked   = tx_oen || !suspend_m;

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    bitcnt_d = bitcnt_q;
    zeros_d  = zeros_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;

    if (blocked) begin
      state_d  = RX_IDLE_S;
      active_d = 1'b0;
    end else begin
      case (state_q)
        RX_IDLE_S: begin
          active_d = 1'b0;
          if (ls_q == LS_K) begin
            state_d = RX_SYNC_S;
            prev_d  = 1'b1;
            ones_d  = '0;
            zeros_d = '0;
          end
        end

        RX_SYNC_S: begin
          if (smp) begin
            if (se0 || stuff_err) begin
              state_d = RX_IDLE_S;
            end else begin
              prev_d = lvl;
              if (stuffed) begin
                ones_d = '0;
              end else if (dbit) begin
                ones_d = ones_q + 3'd1;
                if (zeros_q == ZEROS_MIN) begin
                  state_d  = RX_DATA_S;
                  active_d = 1'b1;
                  bitcnt_d = '0;
                end else begin
                  zeros_d = '0;
                end
              end else begin
                ones_d = '0;
                if (zeros_q != ZEROS_MIN) zeros_d = zeros_q + 1'b1;
              end
            end
          end
        end

        RX_DATA_S: begin
          if (smp) begin
            if (se0) begin
              cnt_d = '0;
              if (bitcnt_q == 3'd0) begin
                state_d = RX_EOP_S;
              end else begin
                state_d  = RX_ERR_S;
                err_d    = 1'b1;
                active_d = 1'b0;
              end
            end else if (stuff_err) begin
              state_d  = RX_ERR_S;
              err_d    = 1'b1;
              active_d = 1'b0;
              cnt_d    = '0;
            end else begin
              prev_d = lvl;
              if (stuffed) begin
                ones_d = '0;
              end else begin
                ones_d   = dbit ? ones_q + 3'd1 : 3'd0;
                shift_d  = {dbit, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                  data_d  = shift_d;
                  valid_d = 1'b1;
                end
              end
            end
          end
        end

        // SE0 seen on four consecutive samples is a bus reset, not an EOP.
        RX_EOP_S: begin
          if (smp) begin
            if (se0) begin
              if (cnt_q == 2'd2) begin
                state_d  = RX_IDLE_S;
                active_d = 1'b0;
              end else begin
                cnt_d = cnt_q + 2'd1;
              end
            end else begin
              state_d  = RX_IDLE_S;
              active_d = 1'b0;
            end
          end
        end

        RX_ERR_S: begin
          active_d = 1'b0;
          if (smp) begin
            if (ls_q == LS_J) begin
              if (cnt_q == 2'd1) state_d = RX_IDLE_S;
              else               cnt_d   = cnt_q + 2'd1;
            end else begin
              cnt_d = '0;
            end
          end
        end

        default: begin
          state_d  = RX_IDLE_S;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // Stage p3: FSM, counters and registered UTMI outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RX_IDLE_S;
      ones_q   <= '0;
      bitcnt_q <= '0;
      zeros_q  <= '0;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      bitcnt_q <= bitcnt_d;
      zeros_q  <= zeros_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign line_state = ls_q;
  assign data_out   = data_q;
  assign rx_valid   = valid_q;
  assign rx_active  = active_q;
  assign rx_error   = err_q;

endmodule

// File: tb/tb_usb_utm_rx.sv
// Directed bench for usb_utm_rx: drives NRZI/stuffed USB line traffic and checks UTMI rx outputs.
module tb_usb_utm_rx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp_rx, dn_rx, tx_oen, suspend_m;
  logic [1:0] line_state;
  logic [7:0] data_out;
  logic       rx_valid, rx_active, rx_error;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int vcnt = 0, ecnt = 0, both = 0, err_act = 0, valid_cyc = 0;
  logic [7:0] rxq[$];

  logic cur_lvl;
  int   ones;
  int   last_edge_cyc;

  usb_utm_rx #(.CLK_PER_BIT(CPB), .SYNC_ZEROS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .dp_rx     (dp_rx),
    .dn_rx     (dn_rx),
    .tx_oen    (tx_oen),
    .suspend_m (suspend_m),
    .line_state(line_state),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      rxq.push_back(data_out);
      valid_cyc = cyc;
    end
    if (rx_error) begin
      ecnt++;
      if (rx_active) err_act++;
    end
    if (rx_valid && rx_error) both++;
  end

  function automatic logic [7:0] q_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic tx_sym(input logic [1:0] ls);
    {dn_rx, dp_rx} = ls;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic tx_raw(input logic b);
    if (!b) begin
      cur_lvl = ~cur_lvl;
      last_edge_cyc = cyc;
    end
    tx_sym(cur_lvl ? 2'b01 : 2'b10);
  endtask

  task automatic tx_bit(input logic b);
    tx_raw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      tx_raw(1'b0);
      ones = 0;
    end
  endtask

  task automatic tx_sync();
    cur_lvl = 1'b1;
    ones = 0;
    repeat (7) tx_bit(1'b0);
    tx_bit(1'b1);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_eop();
    tx_sym(2'b00);
    tx_sym(2'b00);
    tx_sym(2'b01);
    cur_lvl = 1'b1;
  endtask

  task automatic tx_idle(input int n);
    repeat (n) tx_sym(2'b01);
    cur_lvl = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {dn_rx, dp_rx} = 2'b01;
    tx_oen = 1'b0;
    suspend_m = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (line_state !== 2'b01) begin bad++; $display("FAIL reset_ls got=%b want=01", line_state); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", rx_active); end
    total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", rx_error); end
    rst = 1'b1;
    tx_idle(4);
  endtask

  task automatic test_idle();
    int errs;
    errs = 0;
    for (int i = 0; i < 20 * CPB; i++) begin
      @(negedge clk);
      total++;
      if (rx_active !== 1'b0 || rx_valid !== 1'b0 || line_state !== 2'b01) begin
        bad++;
        if (errs < 3) $display("FAIL idle_line got act=%b vld=%b ls=%b want act=0 vld=0 ls=01",
                               rx_active, rx_valid, line_state);
        errs++;
      end
    end
  endtask

  task automatic test_packet();
    int v0, e0, q0, n;
    v0 = vcnt; e0 = ecnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'hA5);
    tx_byte(8'hC3);
    tx_sym(2'b00);
    tx_sym(2'b00);
    total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL pkt_active_in_eop got=%b want=1", rx_active); end
    {dn_rx, dp_rx} = 2'b01;
    n = 0;
    while (rx_active === 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    // 3 clk synchroniser + 2 clk to mid-bit sample + 1 clk output register
    total++; if (n != 6) begin bad++; $display("FAIL pkt_active_fall got=%0d want=6 clk after J", n); end
    tx_idle(4);
    total++; if (vcnt - v0 != 2) begin bad++; $display("FAIL pkt_nbytes got=%0d want=2", vcnt - v0); end
    total++; if (q_at(q0) !== 8'hA5) begin bad++; $display("FAIL pkt_byte0 got=%h want=a5", q_at(q0)); end
    total++; if (q_at(q0 + 1) !== 8'hC3) begin bad++; $display("FAIL pkt_byte1 got=%h want=c3", q_at(q0 + 1)); end
    total++; if (ecnt - e0 != 0) begin bad++; $display("FAIL pkt_error got=%0d want=0", ecnt - e0); end
  endtask

  task automatic test_stuff();
    int v0, e0, q0;
    v0 = vcnt; e0 = ecnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'hFF);
    tx_byte(8'h00);
    tx_eop();
    tx_idle(4);
    total++; if (vcnt - v0 != 2) begin bad++; $display("FAIL stuff_nbytes got=%0d want=2", vcnt - v0); end
    total++; if (q_at(q0) !== 8'hFF) begin bad++; $display("FAIL stuff_byte0 got=%h want=ff", q_at(q0)); end
    total++; if (q_at(q0 + 1) !== 8'h00) begin bad++; $display("FAIL stuff_byte1 got=%h want=00", q_at(q0 + 1)); end
    total++; if (ecnt - e0 != 0) begin bad++; $display("FAIL stuff_error got=%0d want=0", ecnt - e0); end
  endtask

  task automatic test_stuff_error();
    int v0, e0, a0, q0;
    v0 = vcnt; e0 = ecnt; a0 = err_act;
    tx_sync();
    repeat (7) tx_raw(1'b1);
    tx_idle(3);
    total++; if (ecnt - e0 != 1) begin bad++; $display("FAIL serr_strobe got=%0d want=1 clk", ecnt - e0); end
    total++; if (vcnt - v0 != 0) begin bad++; $display("FAIL serr_valid got=%0d want=0", vcnt - v0); end
    total++; if (err_act - a0 != 0) begin bad++; $display("FAIL serr_active_with_err got=%0d want=0", err_act - a0); end
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL serr_active got=%b want=0", rx_active); end
    tx_idle(2);
    v0 = vcnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'h81);
    tx_eop();
    tx_idle(4);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL serr_recover_n got=%0d want=1", vcnt - v0); end
    total++; if (q_at(q0) !== 8'h81) begin bad++; $display("FAIL serr_recover_byte got=%h want=81", q_at(q0)); end
  endtask

  task automatic test_misaligned_eop();
    int v0, e0, q0, t_last, lat;
    v0 = vcnt; e0 = ecnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'h5A);
    t_last = last_edge_cyc;
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_eop();
    tx_idle(4);
    lat = valid_cyc - t_last;
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL mis_nbytes got=%0d want=1", vcnt - v0); end
    total++; if (q_at(q0) !== 8'h5A) begin bad++; $display("FAIL mis_byte got=%h want=5a", q_at(q0)); end
    total++; if (ecnt - e0 != 1) begin bad++; $display("FAIL mis_error got=%0d want=1", ecnt - e0); end
    total++; if (lat < 1 || lat > CPB + 4) begin bad++; $display("FAIL mis_latency got=%0d want<=%0d", lat, CPB + 4); end
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL mis_active got=%b want=0", rx_active); end
  endtask

  task automatic test_reset_mid();
    int v0, e0, q0;
    tx_sync();
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL rmid_active_before got=%b want=1", rx_active); end
    rst = 1'b0;
    {dn_rx, dp_rx} = 2'b01;
    @(negedge clk);
    total++; if (line_state !== 2'b01) begin bad++; $display("FAIL rmid_ls got=%b want=01", line_state); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", data_out); end
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL rmid_active got=%b want=0", rx_active); end
    total++; if (rx_valid !== 1'b0 || rx_error !== 1'b0) begin bad++; $display("FAIL rmid_strobes got=%b%b want=00", rx_valid, rx_error); end
    @(negedge clk);
    rst = 1'b1;
    tx_idle(4);
    v0 = vcnt; e0 = ecnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'h3C);
    tx_eop();
    tx_idle(4);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL rmid_recover_n got=%0d want=1", vcnt - v0); end
    total++; if (q_at(q0) !== 8'h3C) begin bad++; $display("FAIL rmid_recover_byte got=%h want=3c", q_at(q0)); end
    total++; if (ecnt - e0 != 0) begin bad++; $display("FAIL rmid_recover_err got=%0d want=0", ecnt - e0); end
  endtask

  task automatic test_tx_oen();
    int v0, e0, q0;
    v0 = vcnt; e0 = ecnt;
    tx_sync();
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b1);
    total++; if (rx_active !== 1'b1) begin bad++; $display("FAIL txoen_active_before got=%b want=1", rx_active); end
    tx_oen = 1'b1;
    @(negedge clk);
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL txoen_active_drop got=%b want=0", rx_active); end
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_eop();
    tx_idle(4);
    tx_oen = 1'b0;
    tx_idle(2);
    total++; if (vcnt - v0 != 0) begin bad++; $display("FAIL txoen_valid got=%0d want=0", vcnt - v0); end
    total++; if (ecnt - e0 != 0) begin bad++; $display("FAIL txoen_error got=%0d want=0", ecnt - e0); end
    v0 = vcnt; q0 = rxq.size();
    tx_sync();
    tx_byte(8'h69);
    tx_eop();
    tx_idle(4);
    total++; if (vcnt - v0 != 1) begin bad++; $display("FAIL txoen_recover_n got=%0d want=1", vcnt - v0); end
    total++; if (q_at(q0) !== 8'h69) begin bad++; $display("FAIL txoen_recover_byte got=%h want=69", q_at(q0)); end
  endtask

  initial begin
    rst = 1'b0;
    dp_rx = 1'b1;
    dn_rx = 1'b0;
    tx_oen = 1'b0;
    suspend_m = 1'b1;
    cur_lvl = 1'b1;
    ones = 0;
    last_edge_cyc = 0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_packet();
    test_stuff();
    test_stuff_error();
    test_misaligned_eop();
    test_reset_mid();
    test_tx_oen();
    total++; if (both != 0) begin bad++; $display("FAIL valid_and_error_together got=%0d want=0", both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
